// File: rtl/vend_ctrl.sv
// vend_ctrl: parametrised vending-machine controller with saturating credit, per-item stock,
//   selection validation, and one-cycle vend / change / coin-reject / sel-error strobes.
// Ports: clk, reset (sync, active-high); coin_valid/coin_value, sel_valid/sel_item, cancel,
//   restock in; credit, vend_valid/vend_item, change_valid/change_value, coin_reject,
//   sel_error, busy, stock_empty out. Every output is registered.
module vend_ctrl #(
  parameter int N_ITEMS    = 4,
  parameter int SEL_W      = 2,
  parameter int COIN_W     = 6,
  parameter int CREDIT_W   = 8,
  parameter int PRICE_BASE = 10,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 200,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_value,
  output logic                coin_reject,
  output logic [1:0]          sel_error,
  output logic                busy,
  output logic [N_ITEMS-1:0]  stock_empty
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0]  MAX_SUM    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [31:0]        N_ITEMS_U  = 32'(N_ITEMS);
  localparam logic [STOCK_W-1:0] INIT_CNT   = STOCK_W'(INIT_STOCK);
  localparam logic               INIT_EMPTY = (INIT_STOCK == 0);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CREDIT  = 2'd1;
  localparam logic [1:0] ERR_STOCK   = 2'd2;
  localparam logic [1:0] ERR_INVALID = 2'd3;

  state_t             state;
  logic [STOCK_W-1:0] stock [N_ITEMS];

  logic                coin_in;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                sel_in_range;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W-1:0] sel_price;
  logic [1:0]          sel_code;

  // Selection checks and coin accumulation, evaluated against current credit/stock.
  always_comb begin
    coin_in      = coin_valid && (coin_value != '0);
    // One extra bit so an overflowing sum is seen rather than wrapped.
    coin_sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
    coin_fits    = (coin_sum <= MAX_SUM);
    sel_in_range = (32'(sel_item) < N_ITEMS_U);
    sel_price    = CREDIT_W'(PRICE_BASE + int'(sel_item) * PRICE_STEP);
    sel_stock    = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (32'(sel_item) == 32'(i)) sel_stock = stock[i];
    end
    if (!sel_in_range)          sel_code = ERR_INVALID;
    else if (sel_stock == '0)   sel_code = ERR_STOCK;
    else if (credit < sel_price) sel_code = ERR_CREDIT;
    else                        sel_code = ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change_value <= '0;
      coin_reject  <= 1'b0;
      sel_error    <= ERR_NONE;
      busy         <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        stock[i]       <= INIT_CNT;
        stock_empty[i] <= INIT_EMPTY;
      end
    end else begin
      // Strobes and their qualified data fall back to zero unless set below.
      vend_valid   <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change_value <= '0;
      coin_reject  <= 1'b0;
      sel_error    <= ERR_NONE;

      case (state)
        S_IDLE: begin
          // Credit is zero here, so coin_sum is just the coin value.
          if (coin_in) begin
            if (coin_fits) begin
              credit <= coin_sum[CREDIT_W-1:0];
              state  <= S_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
          if (sel_valid) sel_error <= sel_in_range ? ERR_CREDIT : ERR_INVALID;
        end

        S_CREDIT: begin
          if (cancel) begin
            state        <= S_CHANGE;
            busy         <= 1'b1;
            change_valid <= (credit != '0);
            change_value <= credit;
            coin_reject  <= coin_in;
          end else if (sel_valid && (sel_code == ERR_NONE)) begin
            state       <= S_VEND;
            busy        <= 1'b1;
            vend_valid  <= 1'b1;
            vend_item   <= sel_item;
            credit      <= credit - sel_price;
            coin_reject <= coin_in;
            for (int i = 0; i < N_ITEMS; i++) begin
              if (32'(sel_item) == 32'(i)) begin
                stock[i]       <= stock[i] - 1'b1;
                stock_empty[i] <= (stock[i] == STOCK_W'(1));
              end
            end
          end else begin
            if (sel_valid) sel_error <= sel_code;
            if (coin_in) begin
              if (coin_fits) credit      <= coin_sum[CREDIT_W-1:0];
              else           coin_reject <= 1'b1;
            end
          end
        end

        S_VEND: begin
          state        <= S_CHANGE;
          change_valid <= (credit != '0);
          change_value <= credit;
          coin_reject  <= coin_in;
        end

        S_CHANGE: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          credit      <= '0;
          coin_reject <= coin_in;
        end

        default: state <= S_IDLE;
      endcase

      // Placed after the case so a reload overrides a same-cycle decrement.
      if (restock && ((state == S_IDLE) || (state == S_CREDIT))) begin
        for (int i = 0; i < N_ITEMS; i++) begin
          stock[i]       <= INIT_CNT;
          stock_empty[i] <= INIT_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed bench for vend_ctrl with hand-computed expectations.
// Uses N_ITEMS=4, SEL_W=3 so an out-of-range item (7) can be selected; prices 10/15/20/25.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_vend_ctrl;

  localparam int N_ITEMS  = 4;
  localparam int SEL_W    = 3;
  localparam int COIN_W   = 6;
  localparam int CREDIT_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                coin_valid;
  logic [COIN_W-1:0]   coin_value;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel_item;
  logic                cancel;
  logic                restock;
  logic [CREDIT_W-1:0] credit;
  logic                vend_valid;
  logic [SEL_W-1:0]    vend_item;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_value;
  logic                coin_reject;
  logic [1:0]          sel_error;
  logic                busy;
  logic [N_ITEMS-1:0]  stock_empty;

  int n_tests = 0;
  int n_fail  = 0;

  vend_ctrl #(
    .N_ITEMS(N_ITEMS), .SEL_W(SEL_W), .COIN_W(COIN_W), .CREDIT_W(CREDIT_W),
    .PRICE_BASE(10), .PRICE_STEP(5), .MAX_CREDIT(200), .STOCK_W(4), .INIT_STOCK(5)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel), .restock(restock),
    .credit(credit), .vend_valid(vend_valid), .vend_item(vend_item),
    .change_valid(change_valid), .change_value(change_value),
    .coin_reject(coin_reject), .sel_error(sel_error), .busy(busy),
    .stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then release all one-shot inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_value = '0;
    sel_valid  = 1'b0;
    sel_item   = '0;
    cancel     = 1'b0;
    restock    = 1'b0;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_value = COIN_W'(v);
    cyc();
  endtask

  task automatic sel(input int i);
    sel_valid = 1'b1;
    sel_item  = SEL_W'(i);
    cyc();
  endtask

  // Five exact-price vends of item 0 (price 10).
  task automatic drain_item0();
    for (int n = 0; n < 5; n++) begin
      coin(10);
      sel(0);
      check("drain_vend", int'(vend_valid), 1);
      cyc();
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1;
    coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_item = '0;
    cancel = 1'b0; restock = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_credit", int'(credit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_vend", int'(vend_valid), 0);
    check("rst_change", int'(change_valid), 0);
    check("rst_err", int'(sel_error), 0);
    check("rst_empty", int'(stock_empty), 0);

    // Exact-price vend, no change.
    coin(10);
    check("c10_credit", int'(credit), 10);
    coin(5);
    check("c15_credit", int'(credit), 15);
    sel(1);
    check("v1_vend", int'(vend_valid), 1);
    check("v1_item", int'(vend_item), 1);
    check("v1_credit", int'(credit), 0);
    check("v1_busy", int'(busy), 1);
    cyc();
    check("v1_nochange", int'(change_valid), 0);
    check("v1_busy_chg", int'(busy), 1);
    check("v1_vend_off", int'(vend_valid), 0);
    cyc();
    check("v1_idle_busy", int'(busy), 0);

    // Vend with change 5.
    coin(20);
    coin(10);
    check("c30_credit", int'(credit), 30);
    sel(3);
    check("v3_vend", int'(vend_valid), 1);
    check("v3_item", int'(vend_item), 3);
    cyc();
    check("v3_change", int'(change_valid), 1);
    check("v3_chg_val", int'(change_value), 5);
    cyc();
    check("v3_chg_off", int'(change_valid), 0);
    check("v3_credit0", int'(credit), 0);
    check("v3_busy", int'(busy), 0);

    // Insufficient credit, then cancel refunds.
    coin(10);
    sel(2);
    check("low_err", int'(sel_error), 1);
    check("low_credit", int'(credit), 10);
    check("low_novend", int'(vend_valid), 0);
    cyc();
    check("err_pulse", int'(sel_error), 0);
    cancel = 1'b1;
    cyc();
    check("cxl_change", int'(change_valid), 1);
    check("cxl_value", int'(change_value), 10);
    check("cxl_busy", int'(busy), 1);
    cyc();
    check("cxl_credit", int'(credit), 0);
    check("cxl_idle", int'(busy), 0);

    // Selections in IDLE: valid item -> 1, invalid item -> 3; cancel ignored.
    sel(0);
    check("idle_sel_err", int'(sel_error), 1);
    sel(7);
    check("idle_inv_err", int'(sel_error), 3);
    cancel = 1'b1;
    cyc();
    check("idle_cxl", int'(change_valid), 0);

    // Drain item 0 and hit out-of-stock.
    drain_item0();
    check("empty0", int'(stock_empty), 1);
    coin(10);
    sel(0);
    check("oos_err", int'(sel_error), 2);
    check("oos_credit", int'(credit), 10);

    // Reset during VEND: transaction aborted, stock reloaded.
    coin(10);
    sel(1);
    check("pre_rst_vend", int'(vend_valid), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rv_credit", int'(credit), 0);
    check("rv_vend", int'(vend_valid), 0);
    check("rv_change", int'(change_valid), 0);
    check("rv_busy", int'(busy), 0);
    check("rv_empty", int'(stock_empty), 0);
    cyc();
    check("rv_nochange", int'(change_valid), 0);

    // Drain again, then restock while in CREDIT.
    drain_item0();
    check("empty0_b", int'(stock_empty), 1);
    coin(10);
    restock = 1'b1;
    cyc();
    check("restock_empty", int'(stock_empty), 0);
    sel(0);
    check("restock_vend", int'(vend_valid), 1);
    // Coin during VEND is returned.
    coin(5);
    check("vend_coin_rej", int'(coin_reject), 1);
    check("vend_nochg", int'(change_valid), 0);
    cyc();

    // Overflow: 63+63+63+6 = 195, then +10 rejected.
    coin(63);
    coin(63);
    coin(63);
    coin(6);
    check("c195_credit", int'(credit), 195);
    coin(10);
    check("ovf_reject", int'(coin_reject), 1);
    check("ovf_credit", int'(credit), 195);
    cyc();
    check("rej_pulse", int'(coin_reject), 0);
    // Coin with accepted selection: coin returned, credit 195-25 = 170.
    coin_valid = 1'b1;
    coin_value = 6'd5;
    sel(3);
    check("acc_coin_rej", int'(coin_reject), 1);
    check("acc_vend", int'(vend_valid), 1);
    check("acc_credit", int'(credit), 170);
    cyc();
    check("acc_chg_val", int'(change_value), 170);
    cyc();

    // Invalid item in CREDIT, coin alongside failed selection is credited.
    coin(10);
    coin_valid = 1'b1;
    coin_value = 6'd5;
    sel(7);
    check("cr_inv_err", int'(sel_error), 3);
    check("cr_inv_credit", int'(credit), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
